// File: rtl/cam_config_seq_pkg.sv
// Shared types and constants for the camera register-table sequencer.
package cam_config_seq_pkg;

  localparam int unsigned ENTRY_W = 16;

  // Reserved table words: end of table, and a fixed-length pause.
  localparam logic [ENTRY_W-1:0] MARK_END = 16'hFFFF;
  localparam logic [ENTRY_W-1:0] MARK_DLY = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_DELAY    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // One table word: sensor register address in the upper byte, value in the lower.
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] value;
  } rom_entry_t;

endpackage

// File: rtl/cam_config_rom.sv
// Register table: synchronous ROM with one cycle of read latency.
module cam_config_rom #(
  parameter int unsigned                     ROM_AW = 8,
  parameter logic [16*(2**ROM_AW)-1:0]       INIT   = '0
) (
  input  logic              i_clk,
  input  logic [ROM_AW-1:0] i_addr,
  output logic [15:0]       o_data
);

  localparam int unsigned DEPTH = 2**ROM_AW;

  logic [15:0] w_mem [DEPTH];
  logic [15:0] r_data;

  // Entry i of the table occupies INIT[16*i +: 16].
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_mem
    assign w_mem[i] = INIT[16*i +: 16];
  end

  // Registered read.
  always_ff @(posedge i_clk) begin
    r_data <= w_mem[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/cam_config_seq.sv
// Walks the register table and issues one SCCB write per entry, with
// support for pause entries and an end-of-table marker.
module cam_config_seq
  import cam_config_seq_pkg::*;
#(
  parameter int unsigned CLK_F   = 25_000_000,
  parameter int unsigned DLY_CYC = CLK_F / 100,
  parameter int unsigned ROM_AW  = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sccb_start,
  output logic [7:0]        o_sccb_addr,
  output logic [7:0]        o_sccb_data,
  input  logic              i_sccb_ready,
  output logic              o_done
);

  localparam int unsigned       CNT_W     = (DLY_CYC < 1) ? 1 : $clog2(DLY_CYC + 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  state_t            r_state;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_start;
  logic [7:0]        r_addr;
  logic [7:0]        r_data;
  logic              r_done;
  logic              r_first;
  logic [CNT_W-1:0]  r_cnt;

  rom_entry_t w_entry;
  logic       w_last;

  assign w_entry = rom_entry_t'(i_rom_data);
  // Last table slot: finish instead of wrapping back to entry 0.
  assign w_last  = (r_rom_addr == ADDR_LAST);

  // Sequencer state, table pointer and registered SCCB request outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= ST_IDLE;
      r_rom_addr <= '0;
      r_start    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rom_addr <= '0;
          if (i_start) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (i_rom_data == MARK_END) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (i_rom_data == MARK_DLY) begin
            r_cnt   <= '0;
            r_state <= ST_DELAY;
          end else begin
            r_addr  <= w_entry.reg_addr;
            r_data  <= w_entry.value;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_sccb_ready) begin
            r_start <= 1'b1;
            r_first <= 1'b1;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Ready may still read high while the master samples the request.
          r_first <= 1'b0;
          if (!r_first && i_sccb_ready) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (r_cnt == CNT_W'(DLY_CYC)) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_state    <= ST_FETCH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_done     <= 1'b0;
            r_rom_addr <= '0;
            r_state    <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_start = r_start;
  assign o_sccb_addr  = r_addr;
  assign o_sccb_data  = r_data;
  assign o_done       = r_done;

endmodule

// File: tb/tb_cam_config_seq.sv
// Directed bench: two sequencer instances, each with its own table ROM and
// a simple SCCB master model that is busy for a fixed time per write.
module tb_cam_config_seq;

  localparam int unsigned DLY_A = 8;
  localparam int unsigned DLY_B = 4;
  localparam logic [16*256-1:0] ROM_A =
    4096'({16'hFFFF, 16'h40D0, 16'hFFF0, 16'h1280});
  localparam logic [16*4-1:0] ROM_B = 64'h0444_0333_0222_0111;

  logic       clk = 1'b0;
  logic       rstn;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;

  // instance A (ROM_AW = 8)
  logic       start_a;
  logic [7:0] rom_addr_a;
  logic [15:0] rom_data_a;
  logic       sccb_start_a;
  logic [7:0] sccb_addr_a, sccb_data_a;
  logic       ready_a, done_a, hold_a;
  logic       r_rdy_a;
  int         r_bcnt_a;

  // instance B (ROM_AW = 2, no end marker)
  logic       start_b;
  logic [1:0] rom_addr_b;
  logic [15:0] rom_data_b;
  logic       sccb_start_b;
  logic [7:0] sccb_addr_b, sccb_data_b;
  logic       ready_b, done_b;
  logic       r_rdy_b;
  int         r_bcnt_b;

  // start-pulse log
  int          n_a = 0;
  int          st_cyc [32];
  logic [15:0] st_ad [32];
  int          done_cyc = 0;
  logic        prev_done_a = 1'b0;
  int          n_b = 0;
  logic [15:0] last_b = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_config_rom #(.ROM_AW(8), .INIT(ROM_A)) u_rom_a (
    .i_clk(clk), .i_addr(rom_addr_a), .o_data(rom_data_a));

  cam_config_seq #(.CLK_F(1000), .DLY_CYC(DLY_A), .ROM_AW(8)) u_dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_start(start_a),
    .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a),
    .o_sccb_start(sccb_start_a), .o_sccb_addr(sccb_addr_a),
    .o_sccb_data(sccb_data_a), .i_sccb_ready(ready_a), .o_done(done_a));

  cam_config_rom #(.ROM_AW(2), .INIT(ROM_B)) u_rom_b (
    .i_clk(clk), .i_addr(rom_addr_b), .o_data(rom_data_b));

  cam_config_seq #(.CLK_F(1000), .DLY_CYC(DLY_B), .ROM_AW(2)) u_dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_start(start_b),
    .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
    .o_sccb_start(sccb_start_b), .o_sccb_addr(sccb_addr_b),
    .o_sccb_data(sccb_data_b), .i_sccb_ready(ready_b), .o_done(done_b));

  // Master model: ready low the cycle after a request, high again 5 cycles after it.
  assign ready_a = r_rdy_a & ~hold_a;
  assign ready_b = r_rdy_b;

  always @(posedge clk) begin
    if (!rstn) begin
      r_rdy_a <= 1'b1; r_bcnt_a <= 0;
    end else if (sccb_start_a) begin
      r_rdy_a <= 1'b0; r_bcnt_a <= 4;
    end else if (r_bcnt_a == 1) begin
      r_rdy_a <= 1'b1; r_bcnt_a <= 0;
    end else if (r_bcnt_a != 0) begin
      r_bcnt_a <= r_bcnt_a - 1;
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      r_rdy_b <= 1'b1; r_bcnt_b <= 0;
    end else if (sccb_start_b) begin
      r_rdy_b <= 1'b0; r_bcnt_b <= 4;
    end else if (r_bcnt_b == 1) begin
      r_rdy_b <= 1'b1; r_bcnt_b <= 0;
    end else if (r_bcnt_b != 0) begin
      r_bcnt_b <= r_bcnt_b - 1;
    end
  end

  // Log every request and the cycle o_done rises.
  always @(negedge clk) begin
    if (sccb_start_a && n_a < 32) begin
      st_cyc[n_a] = cyc;
      st_ad[n_a]  = {sccb_addr_a, sccb_data_a};
      n_a++;
    end
    if (done_a && !prev_done_a) done_cyc = cyc;
    prev_done_a = done_a;
    if (sccb_start_b) begin
      last_b = {sccb_addr_b, sccb_data_b};
      n_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int k = 0;
    while (!done_a && k < 300) begin @(negedge clk); k++; end
    check(tag, 32'(done_a), 32'd1);
    tick(1);
  endtask

  task automatic wait_start_a(input string tag);
    int k = 0;
    while (!sccb_start_a && k < 50) begin @(negedge clk); k++; end
    check(tag, 32'(sccb_start_a), 32'd1);
  endtask

  // Two writes, 20 cycles apart (ack + delay entry), done 8 cycles after the second.
  task automatic verify_seq(input int base, input string tag);
    check({tag, "_nstart"}, 32'(n_a - base), 32'd2);
    check({tag, "_w0"},     32'(st_ad[base]),   32'h1280);
    check({tag, "_w1"},     32'(st_ad[base+1]), 32'h40D0);
    check({tag, "_gap"},    32'(st_cyc[base+1] - st_cyc[base]), 32'd20);
    check({tag, "_donelat"}, 32'(done_cyc - st_cyc[base+1]), 32'd8);
    check({tag, "_romaddr"}, 32'(rom_addr_a), 32'd3);
  endtask

  initial begin
    int base;
    logic saw, bad;
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; hold_a = 1'b0;
    tick(3);
    check("rst_romaddr", 32'(rom_addr_a), 32'd0);
    check("rst_start",   32'(sccb_start_a), 32'd0);
    check("rst_addr",    32'(sccb_addr_a), 32'd0);
    check("rst_data",    32'(sccb_data_a), 32'd0);
    check("rst_done",    32'(done_a), 32'd0);
    rstn = 1'b1;
    tick(2);
    check("idle_nostart", 32'(n_a), 32'd0);

    // basic run
    base = n_a;
    pulse_start_a();
    wait_done_a("run1_done");
    verify_seq(base, "run1");

    // restart from DONE
    base = n_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("rerun_donefall", 32'(done_a), 32'd0);
    check("rerun_addr0",    32'(rom_addr_a), 32'd0);
    wait_done_a("rerun_done");
    verify_seq(base, "rerun");

    // i_start during WAIT_ACK and DELAY is ignored
    base = n_a;
    pulse_start_a();
    wait_start_a("ign_firststart");
    pulse_start_a();
    tick(9);
    pulse_start_a();
    wait_done_a("ign_done");
    verify_seq(base, "ign");

    // master held busy while a write is pending
    base = n_a;
    hold_a = 1'b1;
    pulse_start_a();
    tick(2);
    saw = 1'b0; bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sccb_start_a) saw = 1'b1;
      if ({sccb_addr_a, sccb_data_a} != 16'h1280) bad = 1'b1;
      tick(1);
    end
    check("hold_nostart", 32'(saw), 32'd0);
    check("hold_stable",  32'(bad), 32'd0);
    hold_a = 1'b0;
    tick(1);
    check("hold_release_start", 32'(sccb_start_a), 32'd1);
    check("hold_release_ad", 32'({sccb_addr_a, sccb_data_a}), 32'h1280);
    wait_done_a("hold_done");
    check("hold_nstart", 32'(n_a - base), 32'd2);

    // reset during WAIT_ACK
    base = n_a;
    pulse_start_a();
    wait_start_a("rst2_start");
    tick(1);
    rstn = 1'b0;
    @(negedge clk);
    check("rst2_romaddr", 32'(rom_addr_a), 32'd0);
    check("rst2_start",   32'(sccb_start_a), 32'd0);
    check("rst2_addr",    32'(sccb_addr_a), 32'd0);
    check("rst2_data",    32'(sccb_data_a), 32'd0);
    check("rst2_done",    32'(done_a), 32'd0);
    rstn = 1'b1;
    tick(10);
    check("rst2_nostart", 32'(n_a - base), 32'd1);
    pulse_start_a();
    wait_start_a("rst2_replay_start");
    check("rst2_replay_ad", 32'({sccb_addr_a, sccb_data_a}), 32'h1280);
    wait_done_a("rst2_replay_done");
    check("rst2_replay_n", 32'(n_a - base), 32'd3);

    // no end marker in a 4-entry table
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    begin
      int k = 0;
      while (!done_b && k < 300) begin @(negedge clk); k++; end
    end
    check("wrap_done",    32'(done_b), 32'd1);
    tick(1);
    check("wrap_nstart",  32'(n_b), 32'd4);
    check("wrap_last",    32'(last_b), 32'h0444);
    check("wrap_romaddr", 32'(rom_addr_b), 32'd3);
    tick(10);
    check("wrap_hold_addr", 32'(rom_addr_b), 32'd3);
    check("wrap_hold_done", 32'(done_b), 32'd1);
    check("wrap_hold_n",    32'(n_b), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
